// File: rtl/elixirchip_es1_spu_op_acc.sv
// Accumulating SPU operator: folds s_data into a running ADD/AND/OR/XOR result,
// presented on m_data after LATENCY clock-enabled edges.
module elixirchip_es1_spu_op_acc #(
  parameter int    LATENCY    = 1,
  parameter int    DATA_BITS  = 8,
  parameter type   data_t     = logic [DATA_BITS-1:0],
  parameter string OPERATION  = "ADD",
  parameter data_t CLEAR_DATA = '0,
  parameter data_t RESET_DATA = '0,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_clear,
  input  logic                 s_valid,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_carry
);

  localparam int OP_ADD = 0;
  localparam int OP_AND = 1;
  localparam int OP_OR  = 2;
  localparam int OP_XOR = 3;
  localparam int OP_BAD = 4;

  localparam int OP_SEL = (OPERATION == "ADD") ? OP_ADD :
                          (OPERATION == "AND") ? OP_AND :
                          (OPERATION == "OR")  ? OP_OR  :
                          (OPERATION == "XOR") ? OP_XOR : OP_BAD;

  localparam bit IS_ADD = (OP_SEL == OP_ADD);

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("elixirchip_es1_spu_op_acc: LATENCY must be >= 1");
    end
    if (OP_SEL == OP_BAD) begin : g_bad_operation
      $error("elixirchip_es1_spu_op_acc: unknown OPERATION");
    end
    if ((SIMULATION != "true") && (SIMULATION != "false")) begin : g_bad_simulation
      $error("elixirchip_es1_spu_op_acc: SIMULATION must be \"true\" or \"false\"");
    end
    if ((DEBUG != "true") && (DEBUG != "false")) begin : g_bad_debug
      $error("elixirchip_es1_spu_op_acc: DEBUG must be \"true\" or \"false\"");
    end
    if (DEVICE == "") begin : g_bad_device
      $error("elixirchip_es1_spu_op_acc: DEVICE must not be empty");
    end
  endgenerate

  // Stage 0 is the accumulator itself; stages 1..LATENCY-1 are plain delays.
  data_t r_pipe_data  [LATENCY];
  logic  r_pipe_carry [LATENCY];

  data_t              w_acc;
  logic               w_carry;
  logic [DATA_BITS:0] w_sum;
  data_t              w_next_acc;
  logic               w_next_carry;

  assign w_acc   = r_pipe_data[0];
  assign w_carry = r_pipe_carry[0];

  // Next accumulator value: load/clear beat accumulate, accumulate beats hold.
  always_comb begin
    w_sum        = {1'b0, w_acc} + {1'b0, s_data};
    w_next_acc   = w_acc;
    w_next_carry = w_carry;
    if (s_clear) begin
      w_next_acc   = s_valid ? s_data : CLEAR_DATA;
      w_next_carry = 1'b0;
    end else if (s_valid) begin
      case (OP_SEL)
        OP_ADD: begin
          w_next_acc   = w_sum[DATA_BITS-1:0];
          w_next_carry = w_carry | w_sum[DATA_BITS];
        end
        OP_AND: begin
          w_next_acc   = w_acc & s_data;
          w_next_carry = 1'b0;
        end
        OP_OR: begin
          w_next_acc   = w_acc | s_data;
          w_next_carry = 1'b0;
        end
        OP_XOR: begin
          w_next_acc   = w_acc ^ s_data;
          w_next_carry = 1'b0;
        end
        default: begin
          w_next_acc   = w_acc;
          w_next_carry = 1'b0;
        end
      endcase
    end else begin
      w_next_acc   = w_acc;
      w_next_carry = w_carry;
    end
  end

  // Accumulator and delay chain; reset wins even while cke is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_pipe_data[i]  <= RESET_DATA;
        r_pipe_carry[i] <= 1'b0;
      end
    end else if (cke) begin
      r_pipe_data[0]  <= w_next_acc;
      r_pipe_carry[0] <= w_next_carry;
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe_data[i]  <= r_pipe_data[i-1];
        r_pipe_carry[i] <= r_pipe_carry[i-1];
      end
    end
  end

  assign m_data  = r_pipe_data[LATENCY-1];
  assign m_carry = IS_ADD ? r_pipe_carry[LATENCY-1] : 1'b0;

endmodule

// File: tb/tb_elixirchip_es1_spu_op_acc.sv
// Self-checking bench: several operator/latency variants share one input stream,
// checked by directed scenarios and a queue-based reference model on random traffic.
module tb_elixirchip_es1_spu_op_acc;

  localparam int N_INST = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       cke;
  logic [7:0] s_data;
  logic       s_clear;
  logic       s_valid;
  logic [7:0] m_data  [N_INST];
  logic       m_carry [N_INST];

  // Per-instance configuration: 0 ADD, 1 AND, 2 OR, 3 XOR.
  int         lat_c [N_INST] = '{1, 3, 2, 1, 2, 5, 5, 1};
  int         op_c  [N_INST] = '{0, 3, 1, 2, 0, 3, 0, 3};
  logic [7:0] clr_c [N_INST] = '{8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00};

  logic [7:0] mdl_acc [N_INST];
  logic       mdl_cy  [N_INST];
  logic [8:0] hist    [N_INST][$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_acc #(.LATENCY(1), .DATA_BITS(8), .OPERATION("ADD")) u0 (
    .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear),
    .s_valid(s_valid), .m_data(m_data[0]), .m_carry(m_carry[0]));
  elixirchip_es1_spu_op_acc #(.LATENCY(3), .DATA_BITS(8), .OPERATION("XOR")) u1 (
    .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear),
    .s_valid(s_valid), .m_data(m_data[1]), .m_carry(m_carry[1]));
  elixirchip_es1_spu_op_acc #(.LATENCY(2), .DATA_BITS(8), .OPERATION("AND")) u2 (
    .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear),
    .s_valid(s_valid), .m_data(m_data[2]), .m_carry(m_carry[2]));
  elixirchip_es1_spu_op_acc #(.LATENCY(1), .DATA_BITS(8), .OPERATION("OR"),
                              .CLEAR_DATA(8'h55)) u3 (
    .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear),
    .s_valid(s_valid), .m_data(m_data[3]), .m_carry(m_carry[3]));
  elixirchip_es1_spu_op_acc #(.LATENCY(2), .DATA_BITS(8), .OPERATION("ADD")) u4 (
    .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear),
    .s_valid(s_valid), .m_data(m_data[4]), .m_carry(m_carry[4]));
  elixirchip_es1_spu_op_acc #(.LATENCY(5), .DATA_BITS(8), .OPERATION("XOR")) u5 (
    .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear),
    .s_valid(s_valid), .m_data(m_data[5]), .m_carry(m_carry[5]));
  elixirchip_es1_spu_op_acc #(.LATENCY(5), .DATA_BITS(8), .OPERATION("ADD")) u6 (
    .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear),
    .s_valid(s_valid), .m_data(m_data[6]), .m_carry(m_carry[6]));
  elixirchip_es1_spu_op_acc #(.LATENCY(1), .DATA_BITS(8), .OPERATION("XOR")) u7 (
    .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear),
    .s_valid(s_valid), .m_data(m_data[7]), .m_carry(m_carry[7]));

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: accumulate with plain arithmetic, then delay through a queue of
  // LATENCY snapshots taken at each enabled edge; the oldest one is the output.
  task automatic model_edge();
    logic [8:0] sum;
    for (int i = 0; i < N_INST; i++) begin
      if (reset) begin
        mdl_acc[i] = 8'h00;
        mdl_cy[i]  = 1'b0;
        hist[i].delete();
        for (int k = 0; k < lat_c[i]; k++) hist[i].push_back(9'h000);
      end else if (cke) begin
        if (s_clear) begin
          mdl_acc[i] = s_valid ? s_data : clr_c[i];
          mdl_cy[i]  = 1'b0;
        end else if (s_valid) begin
          case (op_c[i])
            0: begin
              sum        = 9'(mdl_acc[i]) + 9'(s_data);
              mdl_acc[i] = sum[7:0];
              mdl_cy[i]  = mdl_cy[i] | sum[8];
            end
            1: mdl_acc[i] = mdl_acc[i] & s_data;
            2: mdl_acc[i] = mdl_acc[i] | s_data;
            default: mdl_acc[i] = mdl_acc[i] ^ s_data;
          endcase
        end
        hist[i].push_back({mdl_cy[i], mdl_acc[i]});
        void'(hist[i].pop_front());
      end
    end
  endtask

  task automatic step(input logic rst, input logic ck, input logic clr,
                      input logic vld, input logic [7:0] d);
    reset   = rst;
    cke     = ck;
    s_clear = clr;
    s_valid = vld;
    s_data  = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    reset = 1'b1; cke = 1'b1; s_clear = 1'b0; s_valid = 1'b0; s_data = 8'h00;

    // Reset state on every variant.
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < N_INST; i++) begin
      check_value($sformatf("reset_data[%0d]", i), 32'(m_data[i]), 32'h00);
      check_value($sformatf("reset_carry[%0d]", i), 32'(m_carry[i]), 32'h0);
    end

    // ADD, latency 1.
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h10);
    check_value("add_load", 32'(m_data[0]), 32'h10);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h20);
    check_value("add_acc1", 32'(m_data[0]), 32'h30);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h30);
    check_value("add_acc2", 32'(m_data[0]), 32'h60);
    check_value("add_carry0", 32'(m_carry[0]), 32'h0);

    // ADD wrap and sticky carry cleared by a load.
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'hF0);
    check_value("wrap_load", 32'(m_data[0]), 32'hF0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h20);
    check_value("wrap_data", 32'(m_data[0]), 32'h10);
    check_value("wrap_carry", 32'(m_carry[0]), 32'h1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h01);
    check_value("reload_data", 32'(m_data[0]), 32'h01);
    check_value("reload_carry", 32'(m_carry[0]), 32'h0);

    // XOR, latency 3.
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'hA5);
    check_value("xor_lat_e1", 32'(m_data[1]), 32'h00);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF);
    check_value("xor_lat_e2", 32'(m_data[1]), 32'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_value("xor_lat_e3", 32'(m_data[1]), 32'hA5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_value("xor_lat_e4", 32'(m_data[1]), 32'h5A);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_value("xor_hold", 32'(m_data[1]), 32'h5A);
    check_value("xor_carry", 32'(m_carry[1]), 32'h0);

    // AND, latency 2, with two cke-low cycles carrying a would-be 0x00.
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF);
    check_value("and_e1", 32'(m_data[2]), 32'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check_value("and_gap1", 32'(m_data[2]), 32'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check_value("and_gap2", 32'(m_data[2]), 32'h00);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h0F);
    check_value("and_e2", 32'(m_data[2]), 32'hFF);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_value("and_final", 32'(m_data[2]), 32'h0F);

    // OR with CLEAR_DATA 0x55, then reset while cke is low.
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'hAA);
    check_value("or_clear", 32'(m_data[3]), 32'h55);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF);
    check_value("or_reset_cke0", 32'(m_data[3]), 32'h00);
    check_value("xor5_reset_cke0", 32'(m_data[5]), 32'h00);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h03);
    check_value("or_after_reset", 32'(m_data[3]), 32'h03);
    check_value("add_after_reset", 32'(m_data[0]), 32'h03);

    // Randomized traffic against the reference model on every variant.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0),
           8'($urandom_range(0, 255)));
      for (int i = 0; i < N_INST; i++) begin
        check_value($sformatf("rnd_data[%0d]@%0d", i, n), 32'(m_data[i]), 32'(hist[i][0][7:0]));
        check_value($sformatf("rnd_carry[%0d]@%0d", i, n), 32'(m_carry[i]), 32'(hist[i][0][8]));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/elixirchip_es1_spu_op_acc.md
# elixirchip_es1_spu_op_acc

Accumulating SPU operator: folds a stream of operand words into a running result with a fixed bitwise or additive operation. It sits directly downstream of the single-cycle logic operators (nand, and, xor, …) and consumes their `m_data` as its `s_data`, turning per-element results into reductions such as AND-all, OR-any, parity or sums. The result is presented after a programmable pipeline latency with the same `cke` / `s_clear` / `s_valid` conventions as the other SPU operators.

## Interface
- `LATENCY`, 1: cycles from sampling `s_*` to the result appearing on `m_data`; must be ≥ 1.
- `DATA_BITS`, 8: operand and accumulator width.
- `data_t`, `logic [DATA_BITS-1:0]`: data type.
- `OPERATION`, "ADD": one of "ADD", "AND", "OR", "XOR".
- `CLEAR_DATA`, '0: accumulator value after a clear-only cycle.
- `RESET_DATA`, '0: accumulator and pipeline value after reset.
- `DEVICE`, "RTL"; `SIMULATION`, "false"; `DEBUG`, "false": passed through, no functional effect.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cke`  in  1  clock enable; low freezes all state.
- `s_data`  in  DATA_BITS  operand.
- `s_clear`  in  1  start a new accumulation.
- `s_valid`  in  1  operand valid.
- `m_data`  out  DATA_BITS  accumulated result.
- `m_carry`  out  1  sticky carry-out (ADD only; constant 0 otherwise).

## Operation
- Internal state: `acc` (DATA_BITS) and `carry` (1).
- Reset has priority over everything, including `cke` = 0. On the edge where reset is sampled:
  - `acc` and every delay stage become `RESET_DATA`.
  - `carry` and all carry stages become 0.
- With reset low and `cke` = 1, the `acc` update uses the priority order below (`OP` is `OPERATION`):
  - `s_clear` & `s_valid`: `acc` ← `s_data`, `carry` ← 0. This is a load, so the first element of a new run is not combined with the stale value.
  - `s_clear` & !`s_valid`: `acc` ← `CLEAR_DATA`, `carry` ← 0.
  - !`s_clear` & `s_valid`: `acc` ← `acc OP s_data`, `carry` ← `carry | carry-out`.
  - Neither asserted: hold.
- ADD arithmetic:
  - Computed at DATA_BITS+1 bits.
  - `acc` keeps the low DATA_BITS bits, so it wraps modulo 2^DATA_BITS.
  - The MSB is the carry-out.
  - `carry` is sticky until the next clear or load.
- AND/OR/XOR are bitwise, with no carry. For these, `carry` is tied to 0.
- Output path:
  - `acc`/`carry` feed a chain of LATENCY−1 plain registers.
  - These registers advance only when `cke` = 1.
  - `m_data`/`m_carry` are the chain output, or `acc`/`carry` directly when LATENCY = 1.
- `cke` = 0 (with reset low): `acc`, `carry` and all delay stages hold. Inputs are ignored that cycle.
- Parameter checks at elaboration:
  - LATENCY < 1 is an error.
  - An unknown `OPERATION` string is an error.

## Timing
- Inputs sampled at edge N (`cke` = 1) appear on `m_data` after the LATENCY-th `cke`-enabled edge counted from N.
  - LATENCY = 1: visible right after edge N.
  - Throughput: one operand per enabled cycle, no stall, no backpressure.
- Only enabled edges count toward latency. Disabled cycles stretch latency without losing data.
- Back-to-back load then accumulate needs no idle cycle. The load value is the operand used by the next accumulate.
- Reset mid-accumulation: discards the running value. The first cycle after reset behaves as a normal operation on `RESET_DATA`, so a `s_valid`-only cycle combines with `RESET_DATA`.
- Reset outputs: `m_data` = `RESET_DATA` and `m_carry` = 0 from the edge after reset is sampled, for at least LATENCY enabled edges or until new data propagates.

## Test plan
- **ADD, DATA_BITS = 8, LATENCY = 1.**
  - Stimulus: load 0x10 (`s_clear` + `s_valid`), then valid 0x20, 0x30.
  - Required: `m_data` = 0x10, 0x30, 0x60 on successive cycles; `m_carry` = 0.
- **ADD wrap.**
  - Stimulus: load 0xF0, valid 0x20, then load 0x01.
  - Required: `m_data` = 0xF0, 0x10 with `m_carry` = 1; then 0x01 with `m_carry` = 0.
- **XOR, LATENCY = 3.**
  - Stimulus: load 0xA5, valid 0xFF, then idle.
  - Required: `m_data` shows 0xA5 three enabled edges after the load, then 0x5A on the next edge, then holds 0x5A.
- **AND with `cke` gaps.**
  - Stimulus: load 0xFF, `cke` low for 2 cycles while `s_valid` asserts 0x00, then `cke` high with valid 0x0F.
  - Required: the 0x00 is ignored and `m_data` ends at 0x0F; the latency count excludes the gap.
- **Clear only, then reset.**
  - Stimulus: `CLEAR_DATA` = 0x55, OR mode; `s_clear` alone → `m_data` = 0x55.
  - Then assert reset with `cke` = 0: every stage = `RESET_DATA` (0x00) on the next edge.
  - Then valid 0x03 → `m_data` = 0x03.
- **Randomized ADD/XOR stream** (random `s_clear`/`s_valid`/`cke`) against a reference model, for LATENCY = 1, 2, 5.
